smvm_result_collector: RTL

- Downstream stage of the SMVM core; consumes its 14-bit half-word result stream (out_valid/data_out).
- Reassembles each 28-bit row result from two consecutive halves (upper half first), tags it with its row index and buffers it in a FIFO.
- Presents results to the host/readback logic over a valid/ready interface.
- Tracks a frame of num_rows results and signals frame completion and error conditions.

---
 rtl/smvm_result_collector.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/smvm_result_collector.sv
// Reassembles 28-bit SMVM row results from pairs of 14-bit halves (upper first),
// tags each with its row index, buffers them in a FIFO and tracks frame completion.
module smvm_result_collector #(
    parameter int HALF_W = 14,
    parameter int RES_W  = 28,
    parameter int DEPTH  = 8,
    parameter int ROW_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic              in_valid,
    input  logic [HALF_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_data,
    output logic [ROW_W-1:0]  out_row,
    output logic              out_last,
    output logic              frame_done,
    output logic              busy,
    output logic              err_overflow,
    output logic              err_split
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [RES_W-1:0]  mem_data [DEPTH];
    logic [ROW_W-1:0]  mem_row  [DEPTH];
    logic              mem_last [DEPTH];

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       level;
    logic [ROW_W-1:0]  num_rows_q;
    logic [ROW_W-1:0]  row_cnt;
    logic [HALF_W-1:0] upper;
    logic              half_pending;
    logic              frame_done_q;
    logic              err_overflow_q;
    logic              err_split_q;

    logic empty;
    logic full;
    logic pop;
    logic start_ok;
    logic push_req;
    logic push;
    logic drop;
    logic row_is_last;
    logic done_cond;

    // Valid/ready: the head transfers on any rising edge where out_valid && out_ready;
    // the head fields are held unchanged while out_valid is high and out_ready is low.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level       = wr_ptr - rd_ptr;
    assign pop         = !empty && out_ready;
    assign start_ok    = (state == S_IDLE) && frame_start && (num_rows != '0);
    assign push_req    = (state == S_RUN) && in_valid && half_pending;
    assign push        = push_req && (!full || pop);
    assign drop        = push_req && !push;
    assign row_is_last = (row_cnt == num_rows_q - ROW_W'(1));
    // The last row is always the newest entry, so the pop that empties the FIFO ends the
    // frame; an already-empty FIFO in DRAIN means the last row was dropped.
    assign done_cond   = (state == S_DRAIN) && (empty || (pop && level == (AW+1)'(1)));

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_ok) state_next = S_RUN;
            S_RUN:   if (push_req && row_is_last) state_next = S_DRAIN;
            S_DRAIN: if (done_cond) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            num_rows_q     <= '0;
            row_cnt        <= '0;
            upper          <= '0;
            half_pending   <= 1'b0;
            frame_done_q   <= 1'b0;
            err_overflow_q <= 1'b0;
            err_split_q    <= 1'b0;
        end else begin
            state        <= state_next;
            frame_done_q <= done_cond;
            if (start_ok) begin
                num_rows_q     <= num_rows;
                row_cnt        <= '0;
                half_pending   <= 1'b0;
                err_overflow_q <= 1'b0;
                err_split_q    <= 1'b0;
            end
            if (state == S_RUN) begin
                if (in_valid) begin
                    if (!half_pending) begin
                        upper        <= data_in;
                        half_pending <= 1'b1;
                    end else begin
                        half_pending <= 1'b0;
                        row_cnt      <= row_cnt + ROW_W'(1);
                    end
                end else if (half_pending) begin
                    half_pending <= 1'b0;
                    err_split_q  <= 1'b1;
                end
            end
            if (drop) err_overflow_q <= 1'b1;
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr[AW-1:0]] <= {upper, data_in};
            mem_row[wr_ptr[AW-1:0]]  <= row_cnt;
            mem_last[wr_ptr[AW-1:0]] <= row_is_last;
        end
    end

    assign out_valid    = !empty;
    assign out_data     = empty ? '0 : mem_data[rd_ptr[AW-1:0]];
    assign out_row      = empty ? '0 : mem_row[rd_ptr[AW-1:0]];
    assign out_last     = empty ? 1'b0 : mem_last[rd_ptr[AW-1:0]];
    assign frame_done   = frame_done_q;
    assign busy         = (state != S_IDLE);
    assign err_overflow = err_overflow_q;
    assign err_split    = err_split_q;

endmodule
